dmem_responder: RTL

//   Data-memory responder: the target end of the core's load/store memory port.
//   It accepts one request at a time through a valid/ready request channel and

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target backed by a
// word-organised RAM, with a programmable number of wait states between
// request acceptance and the RAM access.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [3:0]  i_req_be,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_ready, w_rsp_valid, w_access;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_addr, w_wdata, w_off;
  logic        w_borrow, w_err;
  logic [AW-1:0] w_idx;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request inputs are used; otherwise the captured copy.
  assign w_we    = (r_state == S_IDLE) ? i_req_we    : r_we;
  assign w_be    = (r_state == S_IDLE) ? i_req_be    : r_be;
  assign w_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;

  // 33-bit subtract: the borrow flags addresses below the base.
  assign {w_borrow, w_off} = {1'b0, w_addr} - {1'b0, BASE_ADDR};
  assign w_err = (w_addr[1:0] != 2'b00) | w_borrow | ({1'b0, w_off} >= SPAN);
  assign w_idx = w_off[AW+1:2];

  // Next-state and handshake decode.
  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    w_access    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_access = 1'b1;
            w_next   = S_RESP;
          end else begin
            w_next   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter, request capture and registered response.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_req_valid) begin
        r_we    <= i_req_we;
        r_be    <= i_req_be;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_cnt   <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
        r_err   <= w_err;
      end
    end
  end

  // RAM byte writes; contents survive reset, and reset blocks a pending store.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_access && w_we && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign o_req_ready = w_ready & i_reset_n;
  assign o_rsp_valid = w_rsp_valid & i_reset_n;
  assign o_rsp_rdata = i_reset_n ? r_rdata : 32'd0;
  assign o_rsp_err   = r_err & i_reset_n;
  assign o_busy      = (r_state != S_IDLE) & i_reset_n;

endmodule
